// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_TARGET
    } pc_sel_e;

endpackage

// File: rtl/fetch_unit_pcsel.sv
// Next-PC selection: keep the current PC, step by one word, or take a redirect.
module fetch_pcsel
    import fetch_unit_pkg::*;
(
    input  pc_sel_e     sel_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_next_o,
    output logic [31:0] pc_plus4_o
);

    // Wraps modulo 2^32; redirect target passes through untouched, low bits included.
    assign pc_plus4_o = pc_i + 32'd4;

    always_comb begin
        pc_next_o = pc_i;
        case (sel_i)
            PC_INC:    pc_next_o = pc_plus4_o;
            PC_TARGET: pc_next_o = target_i;
            default:   pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with redirect and stall handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemAddr,
    input  logic        ImemRespValid,
    input  logic [31:0] ImemRespData,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_plus4;
    logic [31:0]  instr_q, instr_d, pcf_q, pcf_d, pcp4_q, pcp4_d;
    logic         valid_q, valid_d;
    pc_sel_e      pc_sel;
    logic         req_fire;

    fetch_pcsel u_pcsel (
        .sel_i      (pc_sel),
        .pc_i       (pc_q),
        .target_i   (PCTargetE),
        .pc_next_o  (pc_d),
        .pc_plus4_o (pc_plus4)
    );

    assign ImemReqValid = (state_q == S_REQ) && reset;
    assign ImemAddr     = pc_q;
    assign req_fire     = ImemReqValid && ImemReqReady;

    always_comb begin
        state_d = state_q;
        pc_sel  = PCSrcE ? PC_TARGET : PC_HOLD;
        instr_d = instr_q;
        pcf_d   = pcf_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        case (state_q)
            S_REQ: begin
                // A redirect in the accept cycle leaves a stale response to drain.
                if (req_fire) state_d = PCSrcE ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (ImemRespValid && !PCSrcE) begin
                    instr_d = ImemRespData;
                    pcf_d   = pc_q;
                    pcp4_d  = pc_plus4;
                    valid_d = 1'b1;
                    pc_sel  = PC_INC;
                    state_d = S_HOLD;
                end else if (ImemRespValid) begin
                    state_d = S_REQ;
                end else if (PCSrcE) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (ImemRespValid) state_d = S_REQ;
            end
            S_HOLD: begin
                if (PCSrcE || !StallF) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcf_q   <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcf_q   <= pcf_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign InstrF   = instr_q;
    assign PCF      = pcf_q;
    assign PCPlus4F = pcp4_q;
    assign ValidF   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table plus randomized run against a transaction-level fetch model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, StallF, PCSrcE, ImemReqReady, ImemRespValid;
    logic [31:0] PCTargetE, ImemRespData;
    logic        ImemReqValid, ValidF, ImemReqValid2, ValidF2;
    logic [31:0] ImemAddr, InstrF, PCF, PCPlus4F;
    logic [31:0] ImemAddr2, InstrF2, PCF2, PCPlus4F2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemAddr(ImemAddr),
        .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ImemReqValid(ImemReqValid2), .ImemReqReady(ImemReqReady), .ImemAddr(ImemAddr2),
        .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
        .InstrF(InstrF2), .PCF(PCF2), .PCPlus4F(PCPlus4F2), .ValidF(ValidF2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst, stall, pcsrc;  logic [31:0] tgt;
        logic rdy, rv;            logic [31:0] rdata;
        logic e_reqv;             logic [31:0] e_addr;
        logic e_vld;              logic [31:0] e_instr;
        logic chk_d;              logic [31:0] e_pcf, e_pcp4;
    } vec_t;

    function automatic vec_t v(logic rst, logic stall, logic pcsrc, logic [31:0] tgt,
                               logic rdy, logic rv, logic [31:0] rdata, logic e_reqv,
                               logic [31:0] e_addr, logic e_vld, logic [31:0] e_instr,
                               logic chk_d, logic [31:0] e_pcf, logic [31:0] e_pcp4);
        vec_t r;
        r.rst = rst; r.stall = stall; r.pcsrc = pcsrc; r.tgt = tgt;
        r.rdy = rdy; r.rv = rv; r.rdata = rdata; r.e_reqv = e_reqv; r.e_addr = e_addr;
        r.e_vld = e_vld; r.e_instr = e_instr; r.chk_d = chk_d; r.e_pcf = e_pcf; r.e_pcp4 = e_pcp4;
        return r;
    endfunction

    function automatic logic [31:0] mem(logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[17:2]};
    endfunction

    task automatic drive(logic rst, logic stall, logic pcsrc, logic [31:0] tgt,
                         logic rdy, logic rv, logic [31:0] rdata);
        reset = rst; StallF = stall; PCSrcE = pcsrc; PCTargetE = tgt;
        ImemReqReady = rdy; ImemRespValid = rv; ImemRespData = rdata;
    endtask

    vec_t vecs[$];

    // Transaction-level model state
    logic [31:0] m_pc, m_oaddr, m_haddr;
    logic        m_out, m_kill, m_held;

    initial begin
        // rst stall pcsrc tgt rdy rv rdata | reqv addr vld instr chk pcf pcp4
        vecs.push_back(v(0,0,0,0,0,0,0,             0,0,0,NOP,1,0,0));
        vecs.push_back(v(1,0,0,0,1,0,0,             1,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,1,1,32'h00500093,  0,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,             0,0,1,32'h00500093,1,0,4));
        vecs.push_back(v(1,0,0,0,0,0,0,             1,4,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,1,0,0,             1,4,0,NOP,0,0,0));
        vecs.push_back(v(1,1,0,0,0,1,32'h11111111,  0,0,0,NOP,0,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(1,1,0,0,0,0,0,         0,0,1,32'h11111111,1,4,8));
        vecs.push_back(v(1,0,0,0,0,0,0,             0,0,1,32'h11111111,1,4,8));
        vecs.push_back(v(1,0,0,0,0,0,0,             1,8,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,1,0,0,             1,8,0,NOP,0,0,0));
        vecs.push_back(v(1,0,1,32'h100,0,0,0,       0,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,             0,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,1,32'hDEADBEEF,  0,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,             1,32'h100,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,1,0,0,             1,32'h100,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,1,32'h22222222,  0,0,0,NOP,0,0,0));
        vecs.push_back(v(1,1,1,32'h200,0,0,0,       0,0,1,32'h22222222,1,32'h100,32'h104));
        vecs.push_back(v(1,1,0,0,0,0,0,             1,32'h200,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,1,0,0,             1,32'h200,0,NOP,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,             0,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,1,32'h33333333,  1,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,             1,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,1,32'h302,0,0,0,       1,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,             1,32'h302,0,NOP,0,0,0));
        vecs.push_back(v(1,0,1,32'h400,1,0,0,       1,32'h302,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,1,32'h44444444,  0,0,0,NOP,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,0,             1,32'h400,0,NOP,0,0,0));

        drive(0,0,0,0,0,0,0);
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].pcsrc, vecs[i].tgt,
                  vecs[i].rdy, vecs[i].rv, vecs[i].rdata);
            #1;
            check($sformatf("vec%0d ReqValid", i), {31'b0, ImemReqValid}, {31'b0, vecs[i].e_reqv});
            check($sformatf("vec%0d ValidF", i), {31'b0, ValidF}, {31'b0, vecs[i].e_vld});
            check($sformatf("vec%0d InstrF", i), InstrF, vecs[i].e_instr);
            if (vecs[i].e_reqv) check($sformatf("vec%0d ImemAddr", i), ImemAddr, vecs[i].e_addr);
            if (vecs[i].chk_d) begin
                check($sformatf("vec%0d PCF", i), PCF, vecs[i].e_pcf);
                check($sformatf("vec%0d PCPlus4F", i), PCPlus4F, vecs[i].e_pcp4);
            end
        end

        // PC wraparound from the top of the address space
        @(negedge clk); drive(0,0,0,0,0,0,0);
        @(negedge clk); drive(1,0,0,0,1,0,0); #1;
        check("wrap first addr", ImemAddr2, 32'hFFFF_FFFC);
        @(negedge clk); drive(1,0,0,0,0,1,32'h55555555);
        @(negedge clk); drive(1,0,0,0,0,0,0); #1;
        check("wrap ValidF", {31'b0, ValidF2}, 32'd1);
        check("wrap PCF", PCF2, 32'hFFFF_FFFC);
        check("wrap PCPlus4F", PCPlus4F2, 32'h0);
        @(negedge clk); drive(1,0,0,0,0,0,0); #1;
        check("wrap ReqValid", {31'b0, ImemReqValid2}, 32'd1);
        check("wrap next addr", ImemAddr2, 32'h0);

        // Randomized run against the transaction model
        @(negedge clk); drive(0,0,0,0,0,0,0);
        @(negedge clk);
        m_pc = 32'h0; m_out = 0; m_kill = 0; m_held = 0; m_oaddr = 0; m_haddr = 0;
        for (int c = 0; c < 4000; c++) begin
            logic e_reqv, st, ps, rd, rv, hs, deliver;
            logic [31:0] tg;
            e_reqv = !m_out && !m_held;
            st = ($urandom_range(0, 1) == 1);
            ps = ($urandom_range(0, 9) == 0);
            tg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF), 2'b00};
            rd = ($urandom_range(0, 9) < 7);
            rv = m_out && ($urandom_range(0, 1) == 1);
            drive(1, st, ps, tg, rd, rv, rv ? mem(m_oaddr) : $urandom);
            #1;
            check("rnd ReqValid", {31'b0, ImemReqValid}, {31'b0, e_reqv});
            check("rnd ValidF", {31'b0, ValidF}, {31'b0, m_held});
            check("rnd InstrF", InstrF, m_held ? mem(m_haddr) : NOP);
            if (e_reqv) check("rnd ImemAddr", ImemAddr, m_pc);
            if (m_held) begin
                check("rnd PCF", PCF, m_haddr);
                check("rnd PCPlus4F", PCPlus4F, m_haddr + 32'd4);
            end
            // Advance the model across the coming clock edge
            hs = e_reqv && rd;
            deliver = m_out && rv && !m_kill && !ps;
            if (m_held && (ps || !st)) m_held = 0;
            if (m_out && rv) begin
                m_out = 0;
                if (deliver) begin
                    m_held = 1; m_haddr = m_oaddr; m_pc = m_oaddr + 32'd4;
                end
            end else if (m_out && ps) begin
                m_kill = 1;
            end
            if (hs) begin
                m_out = 1; m_oaddr = m_pc; m_kill = ps;
            end
            if (ps) m_pc = tg;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the InstrF value whenever no instruction is held.
REQ-003 Ports SHALL be:
  clk            in   1   single clock, rising-edge
  reset          in   1   synchronous, active-low (0 = reset)
  StallF         in   1   1 = downstream FD register not accepting
  PCSrcE         in   1   1 = redirect fetch to PCTargetE this cycle
  PCTargetE      in   32  redirect target
  ImemReqValid   out  1   instruction-memory request valid
  ImemReqReady   in   1   memory accepts request
  ImemAddr       out  32  request address
  ImemRespValid  in   1   response data valid
  ImemRespData   in   32  fetched word
  InstrF         out  32  instruction to FD register
  PCF            out  32  address of InstrF
  PCPlus4F       out  32  PCF + 4
  ValidF         out  1   InstrF/PCF/PCPlus4F hold a real instruction

Function
REQ-004 Exactly one memory request SHALL be outstanding at most; responses SHALL be in order.
REQ-005 FSM states SHALL be REQ, WAIT, HOLD, DISCARD.
REQ-006 REQ: ImemReqValid=1, ImemAddr=PC; on ReqValid&ReqReady -> WAIT, or -> DISCARD with PC<=PCTargetE if PCSrcE=1 the same cycle; no handshake and PCSrcE=1 -> PC<=PCTargetE, stay REQ.
REQ-007 WAIT: ImemReqValid=0; RespValid with PCSrcE=0 -> InstrF<=RespData, PCF<=PC, PCPlus4F<=PC+4, ValidF<=1, PC<=PC+4, -> HOLD.
REQ-008 WAIT: RespValid with PCSrcE=1 -> response dropped, PC<=PCTargetE, -> REQ; PCSrcE=1 without RespValid -> PC<=PCTargetE, -> DISCARD.
REQ-009 DISCARD: RespValid -> response dropped, ValidF unchanged (0), -> REQ; PCSrcE=1 -> PC<=PCTargetE (wins over stale PC), stay until response.
REQ-010 HOLD: outputs SHALL stay stable while StallF=1 and PCSrcE=0.
REQ-011 HOLD: instruction SHALL be consumed on the rising edge with StallF=0 -> ValidF<=0, InstrF<=NOP_INSTR, -> REQ.
REQ-012 PCSrcE SHALL take priority over StallF in every state; in HOLD it SHALL clear ValidF, set InstrF<=NOP_INSTR, PC<=PCTargetE, -> REQ.
REQ-013 PC arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000); bit[1:0] of PCTargetE SHALL pass unchanged.
REQ-014 Minimum latency request-accept to ValidF=1 SHALL be 1 cycle after RespValid; best-case throughput 1 instruction per 3 cycles.

Reset
REQ-015 While reset=0 at a rising edge: PC<=RESET_PC, state<=REQ, ValidF<=0, InstrF<=NOP_INSTR, PCF<=0, PCPlus4F<=0.
REQ-016 ImemReqValid SHALL be 0 during any cycle with reset=0.
REQ-017 Reset mid-transaction SHALL abandon the outstanding request; a RespValid arriving in the first REQ state after reset SHALL be ignored.

Structure
REQ-018 A shared package SHALL hold the state enum, NOP_INSTR and the RESET_PC default.
REQ-019 One sub-module, fetch_pcsel (combinational next-PC mux: hold / PC+4 / PCTargetE), SHALL be used; all registers SHALL use synchronous active-low reset.

Verification
REQ-020 Reset release, ReqReady=1, RespValid one cycle after accept with 32'h00500093, StallF=0 -> ImemAddr=0, then ValidF=1, InstrF=32'h00500093, PCF=0, PCPlus4F=4; next request ImemAddr=4.
REQ-021 StallF=1 for 5 cycles in HOLD -> InstrF/PCF/ValidF constant; StallF=0 -> ValidF=0 next cycle, ImemAddr=PC+4.
REQ-022 PCSrcE=1, PCTargetE=32'h0000_0100 while in WAIT, response 32'hDEADBEEF arrives later -> response dropped (ValidF stays 0), next ImemAddr=32'h0000_0100.
REQ-023 PCSrcE=1 and StallF=1 in same HOLD cycle -> ValidF=0, InstrF=32'h0000_0013, next ImemAddr=PCTargetE.
REQ-024 RESET_PC=32'hFFFF_FFFC, one fetch consumed -> PCPlus4F=0, next ImemAddr=32'h0000_0000.
REQ-025 reset=0 asserted during WAIT, RespValid on first post-reset cycle -> ValidF stays 0, ImemAddr=RESET_PC.
